// File: rtl/dipsy_spi_mux_if.sv
// Host/socket signal bundle for dipsy_spi_mux: FTDI MPSSE side plus NUM_SOCK DIPSY sockets.
interface dipsy_spi_mux_if #(
  parameter int NUM_SOCK = 4,
  parameter int SEL_W    = 2
);
  logic                host_sck;
  logic                host_mosi;
  logic                host_miso;
  logic                host_ss;
  logic                host_creset;
  logic                host_done;
  logic [SEL_W-1:0]    host_sel;
  logic [NUM_SOCK-1:0] dipsy_sck;
  logic [NUM_SOCK-1:0] dipsy_mosi;
  logic [NUM_SOCK-1:0] dipsy_ss;
  logic [NUM_SOCK-1:0] dipsy_reset;
  logic [NUM_SOCK-1:0] dipsy_miso;
  logic [NUM_SOCK-1:0] dipsy_done;

  modport master (
    output host_sck, host_mosi, host_ss, host_creset, host_sel, dipsy_miso, dipsy_done,
    input  host_miso, host_done, dipsy_sck, dipsy_mosi, dipsy_ss, dipsy_reset
  );

  modport slave (
    input  host_sck, host_mosi, host_ss, host_creset, host_sel, dipsy_miso, dipsy_done,
    output host_miso, host_done, dipsy_sck, dipsy_mosi, dipsy_ss, dipsy_reset
  );
endinterface

// File: rtl/dipsy_spi_mux.sv
// Routes FTDI MPSSE SPI/CRESET to one of NUM_SOCK DIPSY sockets, selected per frame.
// Optional macro DIPSY_ACT_LED_EN: led_g becomes a per-byte activity stretch instead of ACTIVE.
module dipsy_spi_mux #(
  parameter int NUM_SOCK  = 4,
  parameter int SEL_W     = 2,
  parameter int LED_CNT_W = 22
) (
  input  logic           clk,
  input  logic           resetn,
  dipsy_spi_mux_if.slave bus,
  output logic [15:0]    byte_cnt,
  output logic           sel_err,
  output logic           led_r,
  output logic           led_g,
  output logic           led_b
);
  typedef enum logic [1:0] {IDLE, ACTIVE, REJECT} state_e;

  localparam int          HW      = SEL_W + 4;
  localparam int          DW      = 2 ** SEL_W;
  localparam int unsigned NSOCK_U = NUM_SOCK;
  // packed as {sel, creset, ss, mosi, sck}
  localparam logic [HW-1:0] HOST_IDLE = {{SEL_W{1'b0}}, 4'b1100};

  logic [HW-1:0]       host_s1_q, host_s2_q;
  logic                sck_prev_q, ss_prev_q;
  logic [NUM_SOCK-1:0] miso_s1_q, miso_s2_q, done_s1_q, done_s2_q;
  logic [DW-1:0]       miso_ext, done_ext;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
  logic [2:0]          bit_q, bit_d;
  logic [15:0]         byte_q, byte_d;
  logic                err_q, err_d;
  logic                byte_evt;

  logic [NUM_SOCK-1:0] ss_q, ss_d, sck_q, sck_d, mosi_q, mosi_d, rst_q, rst_d;
  logic                miso_q, miso_d, done_q, done_d;
  logic                r_q, r_d, g_q, g_d, b_q, b_d;

  logic                s_sck, s_mosi, s_ss, s_creset;
  logic [SEL_W-1:0]    s_sel;
  logic                sck_rise, ss_fall, ss_rise, sel_ok;

  assign {s_sel, s_creset, s_ss, s_mosi, s_sck} = host_s2_q;
  assign sck_rise = s_sck & ~sck_prev_q;
  assign ss_fall  = ~s_ss & ss_prev_q;
  assign ss_rise  = s_ss & ~ss_prev_q;
  assign sel_ok   = 32'(s_sel) < NSOCK_U;
  assign miso_ext = DW'(miso_s2_q);
  assign done_ext = DW'(done_s2_q);

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    err_d     = err_q;
    byte_evt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          cur_sel_d = s_sel;
          byte_d    = '0;
          err_d     = ~sel_ok;
          bit_d     = '0;
          if (sel_ok) begin
            state_d = ACTIVE;
            // an SCK rise coinciding with frame start is bit 0 of the frame
            if (sck_rise) bit_d = 3'd1;
          end else begin
            state_d = REJECT;
          end
        end else if (sel_ok) begin
          cur_sel_d = s_sel;
        end
      end
      ACTIVE: begin
        if (s_sel != cur_sel_q) err_d = 1'b1;
        if (sck_rise) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            byte_evt = 1'b1;
            if (byte_q != '1) byte_d = byte_q + 16'd1;
          end
        end
        if (ss_rise) state_d = IDLE;
      end
      REJECT: begin
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from next-state values so the register stage adds just one clk.
  always_comb begin
    ss_d   = '1;
    sck_d  = '0;
    mosi_d = '0;
    rst_d  = '1;
    for (int unsigned i = 0; i < NSOCK_U; i++) begin
      if (32'(cur_sel_d) == i) begin
        rst_d[i] = s_creset;
        if (state_d == ACTIVE) begin
          ss_d[i]   = 1'b0;
          sck_d[i]  = s_sck;
          mosi_d[i] = s_mosi;
        end
      end
    end
    miso_d = (state_d == ACTIVE) ? miso_ext[cur_sel_d] : 1'b1;
    done_d = done_ext[cur_sel_d];
    r_d    = ~((state_d == IDLE) && !err_d);
    b_d    = ~((state_d == REJECT) || err_d);
  end

`ifdef DIPSY_ACT_LED_EN
  localparam logic [LED_CNT_W:0] LED_RELOAD = {1'b1, {LED_CNT_W{1'b0}}};
  logic [LED_CNT_W:0] led_cnt_q, led_cnt_d;

  always_comb begin
    led_cnt_d = led_cnt_q;
    if (byte_evt)
      led_cnt_d = LED_RELOAD;
    else if (led_cnt_q != '0)
      led_cnt_d = led_cnt_q - 1'b1;
  end

  assign g_d = (led_cnt_d == '0);

  always_ff @(posedge clk) begin
    if (!resetn) led_cnt_q <= '0;
    else         led_cnt_q <= led_cnt_d;
  end
`else
  assign g_d = (state_d != ACTIVE);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      host_s1_q  <= HOST_IDLE;
      host_s2_q  <= HOST_IDLE;
      sck_prev_q <= 1'b0;
      ss_prev_q  <= 1'b1;
      miso_s1_q  <= '1;
      miso_s2_q  <= '1;
      done_s1_q  <= '0;
      done_s2_q  <= '0;
      state_q    <= IDLE;
      cur_sel_q  <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      err_q      <= 1'b0;
      ss_q       <= '1;
      sck_q      <= '0;
      mosi_q     <= '0;
      rst_q      <= '1;
      miso_q     <= 1'b1;
      done_q     <= 1'b0;
      r_q        <= 1'b0;
      g_q        <= 1'b1;
      b_q        <= 1'b1;
    end else begin
      host_s1_q  <= {bus.host_sel, bus.host_creset, bus.host_ss, bus.host_mosi, bus.host_sck};
      host_s2_q  <= host_s1_q;
      sck_prev_q <= s_sck;
      ss_prev_q  <= s_ss;
      miso_s1_q  <= bus.dipsy_miso;
      miso_s2_q  <= miso_s1_q;
      done_s1_q  <= bus.dipsy_done;
      done_s2_q  <= done_s1_q;
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      err_q      <= err_d;
      ss_q       <= ss_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      rst_q      <= rst_d;
      miso_q     <= miso_d;
      done_q     <= done_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign bus.dipsy_ss    = ss_q;
  assign bus.dipsy_sck   = sck_q;
  assign bus.dipsy_mosi  = mosi_q;
  assign bus.dipsy_reset = rst_q;
  assign bus.host_miso   = miso_q;
  assign bus.host_done   = done_q;
  assign byte_cnt        = byte_q;
  assign sel_err         = err_q;
  assign led_r           = r_q;
  assign led_g           = g_q;
  assign led_b           = b_q;
endmodule

// File: tb/tb_dipsy_spi_mux.sv
// Bench for dipsy_spi_mux: a 4-socket and a 3-socket instance share one host, checked against a frame-level model.
module tb_dipsy_spi_mux;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       h_sck = 1'b0, h_mosi = 1'b0, h_ss = 1'b1, h_creset = 1'b1;
  logic [1:0] h_sel = 2'd0;
  logic [3:0] m4 = '1, d4 = 4'b1010;
  logic [2:0] m3 = '1, d3 = 3'b101;

  dipsy_spi_mux_if #(.NUM_SOCK(4), .SEL_W(2)) if4 ();
  dipsy_spi_mux_if #(.NUM_SOCK(3), .SEL_W(2)) if3 ();

  assign if4.host_sck = h_sck;   assign if3.host_sck = h_sck;
  assign if4.host_mosi = h_mosi; assign if3.host_mosi = h_mosi;
  assign if4.host_ss = h_ss;     assign if3.host_ss = h_ss;
  assign if4.host_creset = h_creset; assign if3.host_creset = h_creset;
  assign if4.host_sel = h_sel;   assign if3.host_sel = h_sel;
  assign if4.dipsy_miso = m4;    assign if3.dipsy_miso = m3;
  assign if4.dipsy_done = d4;    assign if3.dipsy_done = d3;

  logic [15:0] bc4, bc3;
  logic        se4, se3, r4, g4, b4, r3, g3, b3;

  dipsy_spi_mux #(.NUM_SOCK(4), .SEL_W(2), .LED_CNT_W(4)) u4 (
    .clk(clk), .resetn(resetn), .bus(if4), .byte_cnt(bc4), .sel_err(se4),
    .led_r(r4), .led_g(g4), .led_b(b4));
  dipsy_spi_mux #(.NUM_SOCK(3), .SEL_W(2), .LED_CNT_W(4)) u3 (
    .clk(clk), .resetn(resetn), .bus(if3), .byte_cnt(bc3), .sel_err(se3),
    .led_r(r3), .led_g(g3), .led_b(b3));

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- frame-level model ----------------
  typedef struct packed {
    bit            sck, mosi, ss, cr;
    bit [1:0]      sel;
    bit [1:0][3:0] miso, done;
  } samp_t;

  localparam samp_t IDLE_S = '{sck: 1'b0, mosi: 1'b0, ss: 1'b1, cr: 1'b1, sel: 2'd0,
                               miso: '1, done: '0};
`ifdef DIPSY_ACT_LED_EN
  localparam logic [2:0] LMASK = 3'b101;
`else
  localparam logic [2:0] LMASK = 3'b111;
`endif

  samp_t hq[$];
  int    nsock[2] = '{4, 3};
  int    mode[2];   // 0 idle, 1 routing a frame, 2 rejected frame
  int    msel[2], bits[2];
  bit    err[2];
  logic [3:0]  e_ss[2], e_sck[2], e_mo[2], e_rst[2];
  logic        e_miso[2], e_done[2], e_err[2];
  logic [15:0] e_cnt[2];
  logic [2:0]  e_led[2];
  bit    started = 1'b0;

  initial repeat (4) hq.push_front(IDLE_S);

  always @(posedge clk) begin
    samp_t s, v, p;
    bit rise, fall, ssr, act;
    if (!resetn) s = IDLE_S;
    else begin
      s.sck = h_sck; s.mosi = h_mosi; s.ss = h_ss; s.cr = h_creset; s.sel = h_sel;
      s.miso[0] = m4; s.miso[1] = {1'b1, m3};
      s.done[0] = d4; s.done[1] = {1'b0, d3};
    end
    hq.push_front(s);
    void'(hq.pop_back());
    v = hq[2];
    p = hq[3];
    rise = v.sck && !p.sck;
    fall = !v.ss && p.ss;
    ssr  = v.ss && !p.ss;
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        mode[k] = 0; msel[k] = 0; bits[k] = 0; err[k] = 0;
        e_ss[k] = (k == 0) ? 4'hF : 4'h7; e_rst[k] = e_ss[k];
        e_sck[k] = '0; e_mo[k] = '0; e_miso[k] = 1'b1; e_done[k] = 1'b0;
        e_cnt[k] = '0; e_err[k] = 1'b0; e_led[k] = 3'b011;
      end else begin
        if (mode[k] == 0) begin
          if (fall) begin
            msel[k] = int'(v.sel);
            bits[k] = 0;
            err[k]  = msel[k] >= nsock[k];
            mode[k] = err[k] ? 2 : 1;
            if (mode[k] == 1 && rise) bits[k] = 1;
          end else if (int'(v.sel) < nsock[k]) msel[k] = int'(v.sel);
        end else if (mode[k] == 1) begin
          if (int'(v.sel) != msel[k]) err[k] = 1'b1;
          if (rise) bits[k]++;
          if (ssr) mode[k] = 0;
        end else if (ssr) mode[k] = 0;

        e_ss[k] = '0; e_sck[k] = '0; e_mo[k] = '0; e_rst[k] = '0;
        for (int i = 0; i < nsock[k]; i++) begin
          act = (mode[k] == 1) && (msel[k] == i);
          e_ss[k][i]  = !act;
          e_sck[k][i] = act && v.sck;
          e_mo[k][i]  = act && v.mosi;
          e_rst[k][i] = (msel[k] == i) ? v.cr : 1'b1;
        end
        e_miso[k] = (mode[k] == 1) ? v.miso[k][msel[k]] : 1'b1;
        e_done[k] = (msel[k] < nsock[k]) ? v.done[k][msel[k]] : 1'b0;
        e_cnt[k]  = (bits[k] / 8 > 65535) ? 16'hFFFF : 16'(bits[k] / 8);
        e_err[k]  = err[k];
        e_led[k]  = {!(mode[k] == 0 && !err[k]), mode[k] != 1, !(mode[k] == 2 || err[k])};
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("u4.dipsy_ss", 32'(if4.dipsy_ss), 32'(e_ss[0]));
      chk("u4.dipsy_sck", 32'(if4.dipsy_sck), 32'(e_sck[0]));
      chk("u4.dipsy_mosi", 32'(if4.dipsy_mosi), 32'(e_mo[0]));
      chk("u4.dipsy_reset", 32'(if4.dipsy_reset), 32'(e_rst[0]));
      chk("u4.host_miso", 32'(if4.host_miso), 32'(e_miso[0]));
      chk("u4.host_done", 32'(if4.host_done), 32'(e_done[0]));
      chk("u4.byte_cnt", 32'(bc4), 32'(e_cnt[0]));
      chk("u4.sel_err", 32'(se4), 32'(e_err[0]));
      chk("u4.leds", 32'({r4, g4, b4} & LMASK), 32'(e_led[0] & LMASK));
      chk("u3.dipsy_ss", 32'(if3.dipsy_ss), 32'(e_ss[1]));
      chk("u3.dipsy_sck", 32'(if3.dipsy_sck), 32'(e_sck[1]));
      chk("u3.dipsy_mosi", 32'(if3.dipsy_mosi), 32'(e_mo[1]));
      chk("u3.dipsy_reset", 32'(if3.dipsy_reset), 32'(e_rst[1]));
      chk("u3.host_miso", 32'(if3.host_miso), 32'(e_miso[1]));
      chk("u3.host_done", 32'(if3.host_done), 32'(e_done[1]));
      chk("u3.byte_cnt", 32'(bc3), 32'(e_cnt[1]));
      chk("u3.sel_err", 32'(se3), 32'(e_err[1]));
      chk("u3.leds", 32'({r3, g3, b3} & LMASK), 32'(e_led[1] & LMASK));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic spi_byte(input int sock, input logic [7:0] mo, input logic [7:0] mi,
                          output logic [7:0] got);
    for (int b = 7; b >= 0; b--) begin
      h_mosi = mo[b];
      for (int i = 0; i < 4; i++) m4[i] = (i == sock) ? mi[b] : ~mi[b];
      for (int i = 0; i < 3; i++) m3[i] = (i == sock) ? mi[b] : ~mi[b];
      repeat (8) @(negedge clk);
      h_sck = 1'b1;
      got[b] = if4.host_miso;
      repeat (8) @(negedge clk);
      h_sck = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] got;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      h_sck = 1'($urandom); h_mosi = 1'($urandom); h_ss = 1'($urandom);
      h_creset = 1'($urandom); h_sel = 2'($urandom);
      m4 = 4'($urandom); d4 = 4'($urandom); m3 = 3'($urandom); d3 = 3'($urandom);
    end
    chk("rst_ss", 32'(if4.dipsy_ss), 32'h0000000F);
    chk("rst_leds", 32'({r4, g4, b4}), 32'h00000003);
    chk("rst_byte_cnt", 32'(bc4), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    h_sck = 1'b0; h_mosi = 1'b0; h_ss = 1'b1; h_creset = 1'b1; h_sel = 2'd0;
    m4 = '1; m3 = '1; d4 = 4'b1010; d3 = 3'b101;
    repeat (4) @(negedge clk);

    // three bytes on socket 2, MISO returns 0xA5
    h_sel = 2'd2;
    repeat (4) @(negedge clk);
    h_ss = 1'b0;
    repeat (4) @(negedge clk);
    chk("frame_ss_sock2", 32'(if4.dipsy_ss), 32'h0000000B);
    spi_byte(2, 8'h3C, 8'hA5, got);
    chk("miso_A5", 32'(got), 32'h000000A5);
    spi_byte(2, 8'hC3, 8'h5A, got);
    chk("miso_5A", 32'(got), 32'h0000005A);
    spi_byte(2, 8'hFF, 8'h00, got);
    repeat (4) @(negedge clk);
    h_ss = 1'b1;
    repeat (6) @(negedge clk);
    chk("bytes_3", 32'(bc4), 32'h3);
    chk("err_clear", 32'(se4), 32'h0);
    chk("idle_miso", 32'(if4.host_miso), 32'h1);

    // sel 3: routed on the 4-socket part, rejected on the 3-socket part
    h_sel = 2'd3;
    repeat (4) @(negedge clk);
    h_ss = 1'b0;
    repeat (5) @(negedge clk);
    spi_byte(3, 8'h81, 8'h66, got);
    chk("rej_ss", 32'(if3.dipsy_ss), 32'h7);
    chk("rej_miso", 32'(if3.host_miso), 32'h1);
    chk("rej_err", 32'(se3), 32'h1);
    chk("rej_led_b", 32'(b3), 32'h0);
    h_ss = 1'b1;
    repeat (6) @(negedge clk);
    chk("rej_bytes", 32'(bc3), 32'h0);
    chk("sock3_bytes", 32'(bc4), 32'h1);

    // select moves 1->0 mid-frame: routing holds, error latches
    h_sel = 2'd1;
    repeat (4) @(negedge clk);
    h_ss = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(1, 8'h12, 8'hC9, got);
    h_sel = 2'd0;
    spi_byte(1, 8'h34, 8'h3E, got);
    chk("sel_move_miso", 32'(got), 32'h3E);
    repeat (4) @(negedge clk);
    h_ss = 1'b1;
    repeat (6) @(negedge clk);
    chk("sel_move_err", 32'(se4), 32'h1);
    chk("sel_move_bytes", 32'(bc4), 32'h2);
    chk("sel_move_leds", 32'({r4, b4}), 32'h2);
    h_sel = 2'd2;
    repeat (4) @(negedge clk);
    h_ss = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_cleared_next", 32'(se4), 32'h0);
    h_ss = 1'b1;
    repeat (6) @(negedge clk);

    // CRESET before a frame, then reset mid-frame
    h_sel = 2'd1;
    h_creset = 1'b0;
    repeat (5) @(negedge clk);
    chk("creset_u4", 32'(if4.dipsy_reset), 32'hD);
    chk("creset_u3", 32'(if3.dipsy_reset), 32'h5);
    h_ss = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      repeat (8) @(negedge clk);
      h_sck = 1'b1;
      repeat (8) @(negedge clk);
      h_sck = 1'b0;
    end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ss", 32'(if4.dipsy_ss), 32'hF);
    chk("midrst_reset", 32'(if4.dipsy_reset), 32'hF);
    chk("midrst_bytes", 32'(bc4), 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    h_ss = 1'b1; h_creset = 1'b1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end
endmodule
